// File: rtl/wrr_grant_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin grant arbiter.
// onehot_to_idx scans a fixed PICK_MAX_N-bit vector, so N is limited to 32.
package arb_pkg;

  localparam int unsigned WEIGHT_W   = 4;
  localparam int unsigned PICK_MAX_N = 32;

  typedef logic [WEIGHT_W-1:0] weight_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits for tiny N.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Position of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned onehot_to_idx(input logic [PICK_MAX_N-1:0] v);
    int unsigned r;
    logic        found;
    r     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < PICK_MAX_N; i++) begin
      if (!found && v[i]) begin
        r     = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wrr_grant_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set req bit strictly after
// start, wrapping N-1 -> 0; start itself is considered last.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  logic [2*N-1:0]        dbl;
  logic [PICK_MAX_N-1:0] rot;
  int unsigned           sp;
  int unsigned           off;

  assign dbl     = {req, req};
  assign any_req = |req;

  // Rotate so bit 0 of rot is agent start+1, then take the lowest set bit.
  always_comb begin
    sp         = 32'(start) + 1;
    rot        = '0;
    rot[N-1:0] = dbl[sp +: N];
    off        = onehot_to_idx(rot);
    idx        = IW'((sp + off) % N);
  end

endmodule

// File: rtl/wrr_grant_arbiter.sv
// Weighted round-robin arbiter: a grant is held for up to weight[i] acked
// beats and hands over to the next requester in the same edge it releases.
module wrr_grant_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned WW = 4,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            ack,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_last
);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q,   gnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [WW-1:0] credit_q, credit_d;
  logic [IW-1:0] last_q,  last_d;

  logic [IW-1:0] pick_start;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [WW-1:0] wsel;
  logic          credit_one;
  logic          release_now;
  logic          load;

  // Idle searches past the frozen pointer; an owner searches past itself.
  assign pick_start = (state_q == ST_OWNED) ? owner_q : last_q;

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .start   (pick_start),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign wsel        = weight[int'(pick_idx)*WW +: WW];
  assign credit_one  = (credit_q == WW'(1));
  assign release_now = (state_q == ST_OWNED) && ((ack && credit_one) || !req[owner_q]);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    last_d   = last_q;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) load = 1'b1;
      end
      ST_OWNED: begin
        if (release_now) begin
          if (pick_any) begin
            load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            owner_d  = '0;
            credit_d = '0;
          end
        end else if (ack) begin
          credit_d = credit_q - WW'(1);
        end
      end
      default: ;
    endcase

    if (load) begin
      state_d         = ST_OWNED;
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      owner_d         = pick_idx;
      credit_d        = (wsel == '0) ? WW'(1) : wsel;
      last_d          = pick_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
      last_q   <= IW'(N - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      last_q   <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == ST_OWNED);
  assign gnt_idx   = owner_q;
  assign gnt_last  = gnt_valid && credit_one;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_valid_gnt:  assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt_q));

endmodule
